// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake and bus signal around mem_port_arbiter.
//   Fetch side : ifetch_req/addr/flush in, ifetch_gnt/rvalid/err/rdata out
//   Data side  : data_req/addr/wr/size/wdata in, data_gnt/rvalid/err/rdata out
//   Memory side: mem_req/addr/wr/size/wdata out, mem_gnt/rvalid/rdata in
// Modport slave is the arbiter's view; modport master is the environment view
// (fetch unit, LSU and memory together).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ifetch_req;
  logic [ADDR_W-1:0] ifetch_addr;
  logic              ifetch_flush;
  logic              ifetch_gnt;
  logic              ifetch_rvalid;
  logic              ifetch_err;
  logic [DATA_W-1:0] ifetch_rdata;

  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [DATA_W-1:0] data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic              data_err;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifetch_req, ifetch_addr, ifetch_flush,
    output ifetch_gnt, ifetch_rvalid, ifetch_err, ifetch_rdata,
    input  data_req, data_addr, data_wr, data_size, data_wdata,
    output data_gnt, data_rvalid, data_err, data_rdata,
    output mem_req, mem_addr, mem_wr, mem_size, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output ifetch_req, ifetch_addr, ifetch_flush,
    input  ifetch_gnt, ifetch_rvalid, ifetch_err, ifetch_rdata,
    output data_req, data_addr, data_wr, data_size, data_wdata,
    input  data_gnt, data_rvalid, data_err, data_rdata,
    input  mem_req, mem_addr, mem_wr, mem_size, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// One transaction at a time: arbitrate in IDLE, hold mem_req in REQ until
// mem_gnt, wait for mem_rvalid in RSP, route the response to the owner.
// Misaligned requests go to ERR and are answered without touching memory.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   bus   - mem_port_arbiter_if.slave (fetch, data and memory handshakes)
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to let fetch win one
// arbitration after STARVE_LIMIT consecutive data grants made while it waited.
// Without it data always beats fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_ERR} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, w_owner_nxt;
  logic              r_drop;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
  logic              r_mem_wr, w_wr_nxt;
  logic [1:0]        r_mem_size, w_size_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_wdata_nxt;

  logic       w_gnt_evt, w_rsp_evt, w_err_evt;
  logic       w_is_fetch, w_is_data, w_f_rsp, w_d_rsp;
  logic       w_flush_hit, w_drop_now;
  logic       w_fetch_prio, w_fetch_wins;
  logic       w_fetch_mis, w_data_mis;
  logic [2:0] w_size_mask;

  // Low-address bits that must be zero for each access size.
  always_comb begin
    w_size_mask = 3'b000;
    case (bus.data_size)
      2'd1:    w_size_mask = 3'b001;
      2'd2:    w_size_mask = 3'b011;
      2'd3:    w_size_mask = 3'b111;
      default: w_size_mask = 3'b000;
    endcase
  end

  assign w_data_mis   = |(bus.data_addr[2:0] & w_size_mask);
  assign w_fetch_mis  = |bus.ifetch_addr[1:0];
  assign w_fetch_wins = bus.ifetch_req & (w_fetch_prio | ~bus.data_req);

  assign w_is_fetch = (r_owner == OWN_FETCH);
  assign w_is_data  = (r_owner == OWN_DATA);

  // A flush only matters while fetch owns a live transaction (REQ/RSP/ERR);
  // it takes effect in the same cycle so a coincident gnt/rvalid is dropped.
  assign w_flush_hit = w_is_fetch & bus.ifetch_flush & (r_state != S_IDLE);
  assign w_drop_now  = r_drop | w_flush_hit;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_starve;

  assign w_fetch_prio = (r_starve == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_starve <= '0;
    else if ((w_gnt_evt & w_is_fetch) | ((r_state == S_IDLE) & ~bus.ifetch_req))
      r_starve <= '0;
    else if (w_gnt_evt & w_is_data & bus.ifetch_req & ~w_fetch_prio)
      r_starve <= r_starve + 1'b1;
  end
`else
  assign w_fetch_prio = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_drop      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_size  <= 2'd0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wr    <= w_wr_nxt;
      r_mem_size  <= w_size_nxt;
      r_mem_wdata <= w_wdata_nxt;
      if (w_state_nxt == S_IDLE) r_drop <= 1'b0;
      else if (w_flush_hit)      r_drop <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_addr_nxt  = r_mem_addr;
    w_wr_nxt    = r_mem_wr;
    w_size_nxt  = r_mem_size;
    w_wdata_nxt = r_mem_wdata;
    w_gnt_evt   = 1'b0;
    w_rsp_evt   = 1'b0;
    w_err_evt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fetch_wins) begin
          w_owner_nxt = OWN_FETCH;
          w_addr_nxt  = bus.ifetch_addr;
          w_wr_nxt    = 1'b0;
          w_size_nxt  = SZ_WORD;
          w_wdata_nxt = '0;
          w_state_nxt = w_fetch_mis ? S_ERR : S_REQ;
        end else if (bus.data_req) begin
          w_owner_nxt = OWN_DATA;
          w_addr_nxt  = bus.data_addr;
          w_wr_nxt    = bus.data_wr;
          w_size_nxt  = bus.data_size;
          w_wdata_nxt = bus.data_wdata;
          w_state_nxt = w_data_mis ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          w_gnt_evt   = 1'b1;
          w_state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.mem_rvalid) begin
          w_rsp_evt   = 1'b1;
          w_state_nxt = S_IDLE;
          w_owner_nxt = OWN_NONE;
        end
      end
      S_ERR: begin
        w_gnt_evt   = 1'b1;
        w_rsp_evt   = 1'b1;
        w_err_evt   = 1'b1;
        w_state_nxt = S_IDLE;
        w_owner_nxt = OWN_NONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_f_rsp = w_rsp_evt & w_is_fetch & ~w_drop_now;
  assign w_d_rsp = w_rsp_evt & w_is_data;

  assign bus.ifetch_gnt    = w_gnt_evt & w_is_fetch & ~w_drop_now;
  assign bus.ifetch_rvalid = w_f_rsp;
  assign bus.ifetch_err    = w_f_rsp & w_err_evt;
  assign bus.ifetch_rdata  = (w_f_rsp & ~w_err_evt) ? bus.mem_rdata : '0;

  // Store acknowledges carry no data.
  assign bus.data_gnt    = w_gnt_evt & w_is_data;
  assign bus.data_rvalid = w_d_rsp;
  assign bus.data_err    = w_d_rsp & w_err_evt;
  assign bus.data_rdata  = (w_d_rsp & ~w_err_evt & ~r_mem_wr) ? bus.mem_rdata : '0;

  assign bus.mem_req   = (r_state == S_REQ);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_size  = r_mem_size;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus();
  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0;
  // memory responder model
  int gnt_lat = 1, rv_lat = 1, req_age = 0, pend = 0;
  bit armed = 0;
  logic [63:0] rd_val = '0;
  int flush_at = -1;
  bit hold = 0, clr_d = 0, clr_f = 0;
  // observations
  int n_memreq, n_memrv, n_dgnt, n_drv, n_fgnt, n_frv, n_stray, first_req_c;
  int dgnt_c, drv_c, fgnt_c, frv_c;
  logic [63:0] d_rdata, f_rdata, dg_addr, fg_addr, dg_wdata;
  logic d_err, f_err, dg_wr, fg_wr;
  logic [1:0] dg_size, fg_size;
  int seq[$];

  task automatic clear_stats();
    n_memreq = 0; n_memrv = 0; n_dgnt = 0; n_drv = 0; n_fgnt = 0; n_frv = 0;
    n_stray = 0; first_req_c = -1; dgnt_c = -1; drv_c = -1; fgnt_c = -1; frv_c = -1;
    d_rdata = 'x; f_rdata = 'x; d_err = 1'bx; f_err = 1'bx; seq.delete();
  endtask

  // One clock: drive inputs 1ns after the edge, sample 2ns after the edge.
  task automatic step();
    @(posedge clk); #1; cyc++;
    if (clr_d) begin bus.data_req = 1'b0; clr_d = 0; end
    if (clr_f) begin bus.ifetch_req = 1'b0; clr_f = 0; end
    bus.ifetch_flush = (cyc == flush_at);
    if (bus.mem_req) begin req_age++; bus.mem_gnt = (req_age == gnt_lat); end
    else begin req_age = 0; bus.mem_gnt = 1'b0; end
    bus.mem_rvalid = 1'b0;
    if (armed) begin
      if (pend > 0) pend--;
      if (pend == 0) begin bus.mem_rvalid = 1'b1; armed = 0; end
    end
    if (bus.mem_gnt) begin armed = 1; pend = rv_lat; end
    bus.mem_rdata = rd_val;
    #1;
    if (bus.mem_req) begin n_memreq++; if (first_req_c < 0) first_req_c = cyc; end
    if (bus.mem_rvalid) n_memrv++;
    if (bus.data_gnt) begin
      n_dgnt++; dgnt_c = cyc; seq.push_back(1);
      dg_addr = bus.mem_addr; dg_wr = bus.mem_wr; dg_size = bus.mem_size; dg_wdata = bus.mem_wdata;
      if (!hold) clr_d = 1;
    end
    if (bus.ifetch_gnt) begin
      n_fgnt++; fgnt_c = cyc; seq.push_back(2);
      fg_addr = bus.mem_addr; fg_wr = bus.mem_wr; fg_size = bus.mem_size;
      if (!hold) clr_f = 1;
    end
    if (bus.data_rvalid) begin n_drv++; drv_c = cyc; d_rdata = bus.data_rdata; d_err = bus.data_err; end
    if (bus.ifetch_rvalid) begin n_frv++; frv_c = cyc; f_rdata = bus.ifetch_rdata; f_err = bus.ifetch_err; end
    if (!bus.data_rvalid && (bus.data_err || bus.data_rdata != '0)) n_stray++;
    if (!bus.ifetch_rvalid && (bus.ifetch_err || bus.ifetch_rdata != '0)) n_stray++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ifetch_req = 0; bus.ifetch_addr = '0; bus.ifetch_flush = 0;
    bus.data_req = 0; bus.data_addr = '0; bus.data_wr = 0; bus.data_size = 0; bus.data_wdata = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 64'h1234;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
    checks++; if ({bus.ifetch_gnt, bus.ifetch_rvalid, bus.ifetch_err, bus.data_gnt, bus.data_rvalid, bus.data_err} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes got %b exp 000000",
        {bus.ifetch_gnt, bus.ifetch_rvalid, bus.ifetch_err, bus.data_gnt, bus.data_rvalid, bus.data_err}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wr, bus.mem_size} !== '0) begin
      errors++; $display("FAIL reset_mem_bus got addr %h wdata %h exp 0", bus.mem_addr, bus.mem_wdata); end
    checks++; if ({bus.data_rdata, bus.ifetch_rdata} !== '0) begin
      errors++; $display("FAIL reset_rdata got d %h f %h exp 0", bus.data_rdata, bus.ifetch_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_load();
    clear_stats(); gnt_lat = 2; rv_lat = 3; rd_val = 64'hDEADBEEF_CAFEF00D;
    bus.data_req = 1; bus.data_addr = 64'h1000; bus.data_wr = 0; bus.data_size = 2'd3; t0 = cyc;
    run(12);
    checks++; if (n_memreq != 2) begin errors++; $display("FAIL load_memreq_cycles got %0d exp 2", n_memreq); end
    checks++; if (first_req_c != t0 + 1) begin errors++; $display("FAIL load_memreq_start got %0d exp %0d", first_req_c, t0 + 1); end
    checks++; if (n_dgnt != 1 || n_drv != 1) begin errors++; $display("FAIL load_pulses got gnt %0d rvalid %0d exp 1 1", n_dgnt, n_drv); end
    checks++; if (d_rdata !== 64'hDEADBEEF_CAFEF00D || d_err !== 1'b0) begin
      errors++; $display("FAIL load_rdata got %h err %b exp deadbeefcafef00d 0", d_rdata, d_err); end
    checks++; if (drv_c - dgnt_c != 3) begin errors++; $display("FAIL load_rsp_latency got %0d exp 3", drv_c - dgnt_c); end
    checks++; if (dg_addr !== 64'h1000 || dg_size !== 2'd3 || dg_wr !== 1'b0) begin
      errors++; $display("FAIL load_mem_fields got %h %0d %b exp 1000 3 0", dg_addr, dg_size, dg_wr); end
    checks++; if (n_fgnt + n_frv + n_stray != 0) begin errors++; $display("FAIL load_nonowner got %0d exp 0", n_fgnt + n_frv + n_stray); end
  endtask

  task automatic test_contention();
    clear_stats(); gnt_lat = 1; rv_lat = 2; rd_val = 64'h0123_4567_89AB_CDEF;
    bus.data_req = 1; bus.data_addr = 64'h2008; bus.data_wr = 1; bus.data_size = 2'd2; bus.data_wdata = 64'h55AA_55AA;
    bus.ifetch_req = 1; bus.ifetch_addr = 64'h100;
    run(15);
    checks++; if (n_dgnt != 1 || n_fgnt != 1 || n_drv != 1 || n_frv != 1) begin
      errors++; $display("FAIL cont_counts got %0d %0d %0d %0d exp 1 1 1 1", n_dgnt, n_fgnt, n_drv, n_frv); end
    checks++; if (!(fgnt_c > drv_c && drv_c > 0)) begin errors++; $display("FAIL cont_order got fgnt %0d drv %0d exp fgnt>drv", fgnt_c, drv_c); end
    checks++; if (dg_wr !== 1'b1 || dg_size !== 2'd2 || dg_addr !== 64'h2008 || dg_wdata !== 64'h55AA_55AA) begin
      errors++; $display("FAIL cont_store_fields got %b %0d %h %h exp 1 2 2008 55aa55aa", dg_wr, dg_size, dg_addr, dg_wdata); end
    checks++; if (d_rdata !== 64'h0 || d_err !== 1'b0) begin errors++; $display("FAIL cont_store_ack got %h %b exp 0 0", d_rdata, d_err); end
    checks++; if (fg_wr !== 1'b0 || fg_size !== 2'd2 || fg_addr !== 64'h100) begin
      errors++; $display("FAIL cont_fetch_fields got %b %0d %h exp 0 2 100", fg_wr, fg_size, fg_addr); end
    checks++; if (f_rdata !== 64'h0123_4567_89AB_CDEF || n_stray != 0) begin
      errors++; $display("FAIL cont_fetch_rdata got %h stray %0d exp 0123456789abcdef 0", f_rdata, n_stray); end
  endtask

  task automatic test_misaligned();
    clear_stats(); gnt_lat = 1; rv_lat = 1; rd_val = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.data_req = 1; bus.data_addr = 64'h2003; bus.data_wr = 0; bus.data_size = 2'd1; t0 = cyc;
    run(4);
    checks++; if (n_memreq != 0) begin errors++; $display("FAIL mis_data_memreq got %0d exp 0", n_memreq); end
    checks++; if (dgnt_c != t0 + 1 || drv_c != t0 + 1 || n_drv != 1) begin
      errors++; $display("FAIL mis_data_timing got gnt %0d rv %0d exp %0d", dgnt_c, drv_c, t0 + 1); end
    checks++; if (d_err !== 1'b1 || d_rdata !== 64'h0) begin errors++; $display("FAIL mis_data_err got %b %h exp 1 0", d_err, d_rdata); end
    clear_stats();
    bus.ifetch_req = 1; bus.ifetch_addr = 64'h102; t0 = cyc;
    run(4);
    checks++; if (f_err !== 1'b1 || f_rdata !== 64'h0 || fgnt_c != t0 + 1 || frv_c != t0 + 1) begin
      errors++; $display("FAIL mis_fetch got err %b rdata %h gnt %0d rv %0d exp 1 0 %0d", f_err, f_rdata, fgnt_c, frv_c, t0 + 1); end
    checks++; if (n_memreq != 0) begin errors++; $display("FAIL mis_fetch_memreq got %0d exp 0", n_memreq); end
    clear_stats();
    bus.data_req = 1; bus.data_addr = 64'h2003; bus.data_size = 2'd0;
    run(6);
    checks++; if (d_err !== 1'b0 || n_memreq != 1 || d_rdata !== rd_val) begin
      errors++; $display("FAIL byte_odd_ok got err %b memreq %0d exp 0 1", d_err, n_memreq); end
    clear_stats();
    bus.data_req = 1; bus.data_addr = 64'h2004; bus.data_size = 2'd3;
    run(4);
    checks++; if (d_err !== 1'b1 || n_memreq != 0) begin
      errors++; $display("FAIL dword_at_4 got err %b memreq %0d exp 1 0", d_err, n_memreq); end
  endtask

  task automatic test_flush();
    clear_stats(); gnt_lat = 1; rv_lat = 3; rd_val = 64'hAAAA_0000_BBBB_1111;
    bus.ifetch_req = 1; bus.ifetch_addr = 64'h3000; t0 = cyc; flush_at = t0 + 3;
    run(8);
    flush_at = -1;
    checks++; if (n_fgnt != 1 || n_frv != 0 || n_memrv != 1 || n_stray != 0) begin
      errors++; $display("FAIL flush_drop got gnt %0d rvalid %0d memrv %0d stray %0d exp 1 0 1 0", n_fgnt, n_frv, n_memrv, n_stray); end
    clear_stats(); rd_val = 64'h0000_0000_1234_5678;
    bus.ifetch_req = 1; bus.ifetch_addr = 64'h4000;
    run(8);
    checks++; if (n_frv != 1 || f_rdata !== 64'h1234_5678 || f_err !== 1'b0 || fg_addr !== 64'h4000) begin
      errors++; $display("FAIL flush_next got rv %0d rdata %h addr %h exp 1 12345678 4000", n_frv, f_rdata, fg_addr); end
    clear_stats(); rd_val = 64'h77;
    bus.data_req = 1; bus.data_addr = 64'h1008; bus.data_wr = 0; bus.data_size = 2'd3; t0 = cyc; flush_at = t0 + 2;
    run(8);
    flush_at = -1;
    checks++; if (n_drv != 1 || d_rdata !== 64'h77) begin errors++; $display("FAIL flush_nonowner got rv %0d rdata %h exp 1 77", n_drv, d_rdata); end
  endtask

  task automatic test_reset_mid();
    clear_stats(); gnt_lat = 5; rv_lat = 1;
    bus.data_req = 1; bus.data_addr = 64'h1010; bus.data_wr = 0; bus.data_size = 2'd3;
    run(2);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_in_req got %b exp 1", bus.mem_req); end
    #2; reset = 1'b1; #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 64'h0) begin
      errors++; $display("FAIL rstmid_async got req %b addr %h exp 0 0", bus.mem_req, bus.mem_addr); end
    bus.data_req = 0; armed = 0;
    @(posedge clk); #2; reset = 1'b0;
    clear_stats();
    run(10);
    checks++; if (n_memreq + n_dgnt + n_drv + n_fgnt + n_frv + n_stray != 0) begin
      errors++; $display("FAIL rstmid_stale got req %0d gnt %0d rv %0d exp 0", n_memreq, n_dgnt, n_drv); end
  endtask

  task automatic test_starve();
    int got, exp;
    clear_stats(); hold = 1; gnt_lat = 1; rv_lat = 1; rd_val = 64'h5;
    bus.data_req = 1; bus.data_addr = 64'h5000; bus.data_wr = 0; bus.data_size = 2'd3;
    bus.ifetch_req = 1; bus.ifetch_addr = 64'h6000;
    run(31);
    hold = 0; bus.data_req = 0; bus.ifetch_req = 0;
    run(6);
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp = (i % 5 == 4) ? 2 : 1;
`else
      exp = 1;
`endif
      got = (i < seq.size()) ? seq[i] : 0;
      checks++; if (got != exp) begin errors++; $display("FAIL starve_grant_%0d got %0d exp %0d (1=data 2=fetch)", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_contention();
    test_misaligned();
    test_flush();
    test_reset_mid();
    test_starve();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
